sc_fifo_8x512: RTL and testbench

Single-clock synchronous FIFO, 8 bits wide and 512 entries deep, with an occupancy count and full/empty/almost flags. It decouples a pixel-fetch state machine (writer) from the JPEG encoder's byte reader (reader). The writer throttles itself on `cnt`, fetching only while `cnt < 506`.

---
 rtl/sc_fifo_8x512.sv | 98 +++++++++
 tb/tb_sc_fifo_8x512.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_8x512.sv
// Single-clock 8x512 FIFO with occupancy count and full/empty/almost flags.
// Define SC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered 1-cycle-latency output.
module sc_fifo_8x512 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_MARGIN  = 6,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   cnt
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LEVEL_C = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0]   AE_LEVEL_C = (ADDR_WIDTH+1)'(AE_MARGIN);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Flags decode the registered count, so gating below uses edge-time state.
  assign full         = (cnt_r == DEPTH_C);
  assign empty        = (cnt_r == '0);
  assign almost_full  = (cnt_r >= AF_LEVEL_C);
  assign almost_empty = (cnt_r <= AE_LEVEL_C);
  assign cnt          = cnt_r;

  assign wr_en_s = write & ~full;
  assign rd_en_s = read & ~empty;

  // Storage array; deliberately not reset and untouched by clear.
  always_ff @(posedge clk) begin
    if (!clear && wr_en_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointer and occupancy state; clear discards any same-cycle access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE_C;
        2'b01:   cnt_r <= cnt_r - CNT_ONE_C;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef SC_FIFO_FWFT_EN
  assign data_out = mem_r[rd_ptr_r];
`else
  logic [DATA_WIDTH-1:0] data_out_r;

  // Registered read port: holds its value except on an effective read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= '0;
    end else if (!clear && rd_en_s) begin
      data_out_r <= mem_r[rd_ptr_r];
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;
`endif

endmodule

// File: tb/tb_sc_fifo_8x512.sv
// Self-checking bench for sc_fifo_8x512 (default registered-output build):
// directed vector table, hand-written corner sequences and random traffic against a queue model.
module tb_sc_fifo_8x512;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       write;
  logic       read;
  logic       clear;
  logic [7:0] data_out;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       almost_empty;
  logic [9:0] cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents as a queue plus the last value read out.
  logic [7:0] q[$];
  logic [7:0] dout_m;

  typedef struct {
    logic       w;
    logic       r;
    logic       c;
    logic [7:0] d;
    int         exp_cnt;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[15];

  sc_fifo_8x512 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .write        (write),
    .read         (read),
    .clear        (clear),
    .data_out     (data_out),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .cnt          (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("cnt", int'(cnt), q.size());
    chk("data_out", int'(data_out), int'(dout_m));
    chk("full", int'(full), int'(q.size() == 512));
    chk("almost_full", int'(almost_full), int'(q.size() >= 506));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("almost_empty", int'(almost_empty), int'(q.size() <= 1));
  endtask

  // One clock cycle: drive inputs, advance model by the FIFO rules, compare just after the edge.
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    bit rd_ok;
    bit wr_ok;
    write   = w;
    read    = r;
    clear   = c;
    data_in = d;
    @(posedge clk);
    if (c) begin
      q.delete();
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && (q.size() < 512);
      if (rd_ok) dout_m = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    write   = 1'b0;
    read    = 1'b0;
    clear   = 1'b0;
    data_in = 8'h00;
  endtask

  initial begin
    logic [7:0] first_word;

    // Directed vectors: six writes, six reads, then empty-read and read+write at zero.
    for (int i = 0; i < 6; i++) begin
      vecs[i]     = '{1'b1, 1'b0, 1'b0, 8'(i + 1), i + 1, 8'h00};
      vecs[6 + i] = '{1'b0, 1'b1, 1'b0, 8'h00, 5 - i, 8'(i + 1)};
    end
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h06};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'hAA, 1, 8'h06};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'hAA};

    idle_inputs();
    reset_n = 1'b0;
    dout_m  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d);
      chk("vec_cnt", int'(cnt), vecs[i].exp_cnt);
      chk("vec_data_out", int'(data_out), int'(vecs[i].exp_dout));
      chk("vec_empty", int'(empty), int'(vecs[i].exp_cnt == 0));
      chk("vec_almost_empty", int'(almost_empty), int'(vecs[i].exp_cnt <= 1));
    end

    // Fill to full, watching almost_full threshold, then overflow and read+write at full.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    first_word = 8'($urandom);
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b0, 1'b0, (i == 0) ? first_word : 8'($urandom));
      if (i == 504) chk("af_below_506", int'(almost_full), 0);
      if (i == 505) chk("af_at_506", int'(almost_full), 1);
    end
    chk("full_at_512", int'(full), 1);
    chk("cnt_at_512", int'(cnt), 512);
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("overflow_dropped_cnt", int'(cnt), 512);
    step(1'b1, 1'b1, 1'b0, 8'hC3);
    chk("rw_at_full_cnt", int'(cnt), 511);
    chk("first_word_out", int'(data_out), int'(first_word));

    // Wrap the pointers: prefill 300, drain 300, then fill 512 and drain 512.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    chk("wrap_full", int'(full), 1);
    for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_empty", int'(empty), 1);

    // Sustained read+write at a count of 10.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      chk("rw_cnt_10", int'(cnt), 10);
    end

    // Clear with write at 200, then asynchronous reset mid-stream at 200.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b1, 8'h77);
    chk("clear_cnt", int'(cnt), 0);
    chk("clear_empty", int'(empty), 1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'h11);
    #3;
    reset_n = 1'b0;
    #1;
    q.delete();
    dout_m = 8'h00;
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_data_out", int'(data_out), 0);
    compare_model();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 299) == 0), 8'($urandom));
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
